dmem_responder: RTL

- Memory-side responder for the pipeline's MEM-stage data port. It accepts one load/store request at a time from the core.
- It models a word-organised data SRAM with a programmable wait-state count, byte-lane write strobes for byte/half stores, and lane selection with sign/zero extension for loads.
- It completes every request with a one-cycle response pulse; the core holds MEM stalled until that pulse arrives.

---
 rtl/dmem_responder_pkg.sv | 32 +++
 rtl/dmem_load_align.sv | 36 +++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the MEM-stage data responder: access sizes, FSM states
// and the size/alignment fault rule used on the held request.
package dmem_responder_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_R = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10
  } rsp_state_e;

  // Reserved size or a lane offset that does not fit the access width.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] off);
    logic f;
    case (size)
      MEM_B:   f = 1'b0;
      MEM_H:   f = off[0];
      MEM_W:   f = (off != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half lane of a loaded word and sign- or
// zero-extends it to XLEN; word loads pass through unchanged.
module dmem_load_align
  import dmem_responder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = word[{offset, 3'b000} +: 8];
    half_s = word[{offset[1], 4'b0000} +: 16];
    data   = '0;
    case (size)
      MEM_B: begin
        if (is_unsigned) data = {{(XLEN-8){1'b0}}, byte_s};
        else             data = {{(XLEN-8){byte_s[7]}}, byte_s};
      end
      MEM_H: begin
        if (is_unsigned) data = {{(XLEN-16){1'b0}}, half_s};
        else             data = {{(XLEN-16){half_s[15]}}, half_s};
      end
      MEM_W:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data SRAM behind a single-outstanding request port with a
// programmable wait-state count and a one-cycle completion pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  rsp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx_s;
  logic             fault_s;
  logic [XLEN-1:0]  rd_word_s;
  logic [XLEN-1:0]  load_data_s;
  logic [3:0]       strb_s;
  logic [XLEN-1:0]  wdata_rep_s;
  logic             wr_en_s;

  assign idx_s     = addr_q[IDX_W+1:2];
  assign rd_word_s = mem[idx_s];
  // Any set bit above the word index is outside the array.
  assign fault_s   = size_fault(size_q, addr_q[1:0]) || ((addr_q >> (IDX_W + 2)) != '0);
  assign wr_en_s   = (state_q == ST_ACCESS) && we_q && !fault_s;

  dmem_load_align #(.XLEN(XLEN)) u_align (
    .word        (rd_word_s),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data_s)
  );

  always_comb begin
    strb_s      = 4'b0000;
    wdata_rep_s = wdata_q;
    case (size_q)
      MEM_B: begin
        strb_s      = 4'b0001 << addr_q[1:0];
        wdata_rep_s = {4{wdata_q[7:0]}};
      end
      MEM_H: begin
        strb_s      = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep_s = {2{wdata_q[15:0]}};
      end
      MEM_W:   strb_s = 4'b1111;
      default: strb_s = 4'b0000;
    endcase
  end

  // Array is deliberately not reset; only strobed lanes are written.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s && strb_s[b]) begin
        mem[idx_s][b*8 +: 8] <= wdata_rep_s[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          if (LATENCY == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        resp_valid_d = 1'b1;
        resp_err_d   = fault_s;
        resp_rdata_d = (fault_s || we_q) ? '0 : load_data_s;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
